// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//    Shares the single-port system RAM between two requesters: port 0 (the
//    CPU MAR/MDR path) and port 1 (boot loader / DMA). Exactly one access is in
//    flight at a time. Grants are round-robin, or fixed priority to port 0 when
//    FIXED_PRI is set. Read data comes back with a one-cycle valid strobe to the
//    port that issued the read.
//
// Ports
//    clk, reset            system clock, asynchronous active-high reset
//    pN_req                port N access request (level, held until pN_gnt)
//    pN_we                 port N: 1 = write, 0 = read
//    pN_addr, pN_wdata     port N word address and write data
//    pN_gnt                one-cycle pulse: port N's access is being issued
//    pN_rvalid             one-cycle pulse: pN_rdata holds port N's read data
//    pN_rdata              RAM read data, meaningful only with pN_rvalid
//    mem_address/mem_data  registered RAM address and write data
//    mem_rden/mem_wren     registered RAM enables, never both high
//    mem_q                 RAM read data
//    busy                  high whenever an access is in progress
module mem_port_arbiter #(
   parameter int ADDR_W    = 9,
   parameter int DATA_W    = 32,
   parameter int RD_LAT    = 1,
   parameter int FIXED_PRI = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p1_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_rden,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_q,
   output logic              busy
);

   localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RD_LAT - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RDWAIT
   } state_t;

   state_t            state, state_nxt;
   logic              owner, owner_nxt;
   logic              last_gnt, last_gnt_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [DATA_W-1:0] data_nxt;
   logic              rden_nxt, wren_nxt;
   logic              gnt0_nxt, gnt1_nxt;
   logic              win;
   logic              win_we;
   logic              rd_done;

   // The last RDWAIT cycle is when the RAM output holds the owner's word.
   assign rd_done   = (state == RDWAIT) && (cnt == LAST_CNT);
   assign p0_rvalid = rd_done && !owner;
   assign p1_rvalid = rd_done && owner;
   assign p0_rdata  = mem_q;
   assign p1_rdata  = mem_q;
   assign busy      = (state != IDLE);

   // Next-state and next-output logic. Requests are only looked at in IDLE; the
   // winner's address, data and enable are captured here so the RAM pins are
   // driven straight from flops during ACCESS. mem_wren doubles as the "this
   // access was a write" flag when leaving ACCESS. On a tie in round-robin mode
   // the port that did not win last time is chosen.
   always_comb begin
      state_nxt    = state;
      owner_nxt    = owner;
      last_gnt_nxt = last_gnt;
      cnt_nxt      = cnt;
      addr_nxt     = mem_address;
      data_nxt     = mem_data;
      rden_nxt     = 1'b0;
      wren_nxt     = 1'b0;
      gnt0_nxt     = 1'b0;
      gnt1_nxt     = 1'b0;
      win          = 1'b0;
      win_we       = 1'b0;
      case (state)
         IDLE: begin
            if (p0_req || p1_req) begin
               if (p0_req && p1_req) begin
                  win = (FIXED_PRI != 0) ? 1'b0 : ~last_gnt;
               end else begin
                  win = p1_req;
               end
               win_we       = win ? p1_we : p0_we;
               owner_nxt    = win;
               last_gnt_nxt = win;
               addr_nxt     = win ? p1_addr : p0_addr;
               data_nxt     = win ? p1_wdata : p0_wdata;
               rden_nxt     = !win_we;
               wren_nxt     = win_we;
               gnt0_nxt     = !win;
               gnt1_nxt     = win;
               state_nxt    = ACCESS;
            end
         end
         ACCESS: begin
            cnt_nxt   = '0;
            state_nxt = mem_wren ? IDLE : RDWAIT;
         end
         RDWAIT: begin
            if (cnt == LAST_CNT) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and RAM-pin registers. Reset clears the enables asynchronously so an
   // access caught mid-flight is abandoned, and points the last grant at port 1
   // so port 0 wins the first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         owner       <= 1'b0;
         last_gnt    <= 1'b1;
         cnt         <= '0;
         mem_address <= '0;
         mem_data    <= '0;
         mem_rden    <= 1'b0;
         mem_wren    <= 1'b0;
         p0_gnt      <= 1'b0;
         p1_gnt      <= 1'b0;
      end else begin
         state       <= state_nxt;
         owner       <= owner_nxt;
         last_gnt    <= last_gnt_nxt;
         cnt         <= cnt_nxt;
         mem_address <= addr_nxt;
         mem_data    <= data_nxt;
         mem_rden    <= rden_nxt;
         mem_wren    <= wren_nxt;
         p0_gnt      <= gnt0_nxt;
         p1_gnt      <= gnt1_nxt;
      end
   end

endmodule
